ssd_scan_driver: RTL and testbench



---
 rtl/ssd_scan_driver.sv | 125 ++++++++++++
 tb/tb_ssd_scan_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed BCD-to-7-segment driver for a common-anode display (active-low seg/dp/an).
// Define SSD_HEX_EN to show hex glyphs A-F for codes 10-15; otherwise those codes blank.
module ssd_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [4*DIGITS-1:0]         bcd,
  input  logic [DIGITS-1:0]           dp_in,
  input  logic                        lzb,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [DIGITS-1:0]           an,
  output logic [$clog2(DIGITS)-1:0]   digit_idx
);

  localparam int IDX_W = $clog2(DIGITS);

  logic [DIV_W-1:0]    presc;
  logic [4*DIGITS-1:0] bcd_s;
  logic [DIGITS-1:0]   dp_s;
  logic                lzb_s;
  logic                tick;
  logic                frame_wrap;
  logic [DIGITS-1:0]   zero_from;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                cur_zero;
  logic                blank;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
`ifdef SSD_HEX_EN
      4'd10:   s = 7'b0001000;
      4'd11:   s = 7'b1100000;
      4'd12:   s = 7'b0110001;
      4'd13:   s = 7'b1000010;
      4'd14:   s = 7'b0110000;
      4'd15:   s = 7'b0111000;
`endif
      default: s = '1;
    endcase
    return s;
  endfunction

  assign tick       = (presc == DIV_W'(SCAN_DIV - 1));
  assign frame_wrap = tick && (digit_idx == IDX_W'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      presc     <= '0;
      digit_idx <= '0;
    end else if (tick) begin
      presc     <= '0;
      digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      presc     <= presc + DIV_W'(1);
    end
  end

  // Shadows track the inputs while disabled so re-enable starts from fresh data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_s <= '0;
      dp_s  <= '0;
      lzb_s <= 1'b0;
    end else if (!en || frame_wrap) begin
      bcd_s <= bcd;
      dp_s  <= dp_in;
      lzb_s <= lzb;
    end
  end

  // zero_from[k]: digit k and every digit above it are zero.
  always_comb begin
    zero_from = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      zero_from[i] = ~|(bcd_s >> (4 * i));
    end
  end

  always_comb begin
    cur_code = '0;
    cur_dp   = 1'b0;
    cur_zero = 1'b0;
    an_next  = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_code   = bcd_s[4*i +: 4];
        cur_dp     = dp_s[i];
        cur_zero   = zero_from[i];
        an_next[i] = 1'b0;
      end
    end
    blank = lzb_s && (digit_idx != '0) && cur_zero;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      seg <= '1;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= blank ? '1 : decode(cur_code);
      dp  <= ~cur_dp;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: cycle-level reference model feeds a queue, a monitor checks it.
module tb_ssd_scan_driver;

  localparam int DG = 4;
  localparam int SD = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b1;
  logic        lzb   = 1'b0;
  logic [15:0] bcd   = 16'h1234;
  logic [3:0]  dp_in = 4'b0100;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] idx;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  bit         done  = 1'b0;
  logic [6:0] seg_tab[16];

  // Reference model state: enabled-cycle count since restart and the frame's latched inputs.
  int          n_run = 0;
  logic [15:0] sh_bcd = '0;
  logic [3:0]  sh_dp  = '0;
  logic        sh_lzb = 1'b0;

  always #5 clk = ~clk;

  ssd_scan_driver #(.DIGITS(DG), .SCAN_DIV(SD), .DIV_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bcd(bcd), .dp_in(dp_in), .lzb(lzb),
    .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx)
  );

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
`ifdef SSD_HEX_EN
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000; seg_tab[12] = 7'b0110001;
    seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
`else
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;
`endif
  end

  function automatic exp_t show_digit(int d);
    exp_t e;
    logic [3:0] code;
    bit all_zero;
    code = 4'((sh_bcd >> (4 * d)) & 16'hF);
    all_zero = 1'b1;
    for (int j = d; j < DG; j++)
      if (((sh_bcd >> (4 * j)) & 16'hF) != 0) all_zero = 1'b0;
    e.seg = (sh_lzb && d > 0 && all_zero) ? 7'b1111111 : seg_tab[code];
    e.dp  = ~sh_dp[d];
    e.an  = ~(4'b0001 << d);
    e.idx = 2'(0);
    return e;
  endfunction

  // Model: evaluate on each active edge using the inputs the DUT sees on that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        e = '{seg: 7'b1111111, dp: 1'b1, an: 4'b1111, idx: 2'd0};
        n_run = 0; sh_bcd = '0; sh_dp = '0; sh_lzb = 1'b0;
      end else if (!en) begin
        e = '{seg: 7'b1111111, dp: 1'b1, an: 4'b1111, idx: 2'd0};
        n_run = 0; sh_bcd = bcd; sh_dp = dp_in; sh_lzb = lzb;
      end else begin
        e = show_digit((n_run / SD) % DG);
        if ((n_run % (SD * DG)) == SD * DG - 1) begin
          sh_bcd = bcd; sh_dp = dp_in; sh_lzb = lzb;
        end
        n_run++;
        e.idx = 2'((n_run / SD) % DG);
      end
      q.push_back(e);
    end
  end

  // Monitor: outputs settle after the active edge; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if ({seg, dp, an, digit_idx} !== e) begin
          fails++;
          $display("FAIL outputs cyc=%0d got seg=%b dp=%b an=%b idx=%0d exp seg=%b dp=%b an=%b idx=%0d",
                   cyc, seg, dp, an, digit_idx, e.seg, e.dp, e.an, e.idx);
        end
      end
    end
  end

  initial begin
    #1000000;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: stimulus did not complete (cyc=%0d)", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 1) == 1) v = v | (16'($urandom_range(0, 15)) << (4 * i));
    return v;
  endfunction

  initial begin
    step(3);
    tests++;
    if (seg !== 7'b1111111 || dp !== 1'b1 || an !== 4'b1111 || digit_idx !== 2'd0) begin
      fails++;
      $display("FAIL reset state got seg=%b dp=%b an=%b idx=%0d", seg, dp, an, digit_idx);
    end
    rst_n = 1'b1;
    step(22);
    bcd = 16'h5678;
    step(40);
    lzb = 1'b1; bcd = 16'h0050;
    step(34);
    bcd = 16'h0000;
    step(34);
    lzb = 1'b0; bcd = 16'h00AF; dp_in = 4'b1001;
    step(34);
    step(9);
    en = 1'b0;
    step(2);
    en = 1'b1;
    step(21);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        bcd   = rand_bcd();
        dp_in = 4'($urandom_range(0, 15));
        lzb   = 1'($urandom_range(0, 1));
      end
      if (en && $urandom_range(0, 59) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    rst_n = 1'b1; en = 1'b1;
    step(4);
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
